// File: rtl/rv_decode_stage.sv
// RV32I/RV64I decode stage: combinational RF addresses, registered decode bundle.
// Valid/ready toward fetch and execute, optional one-entry skid, optional M ops.
module rv_decode_stage #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned PC_W = 32,
  parameter bit          SKID = 1'b1,
  parameter bit          EN_M = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [PC_W-1:0] in_pc,
  input  logic            flush,
  output logic [4:0]      rf_rs1_addr,
  output logic [4:0]      rf_rs2_addr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [2:0]      out_funct3,
  output logic [XLEN-1:0] out_imm,
  output logic [23:0]     out_alu,
  output logic [10:0]     out_type,
  output logic            out_illegal
);

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic [XLEN-1:0] imm;
    logic [23:0]     alu;
    logic [10:0]     typ;
    logic            ill;
  } pay_t;

  localparam logic [6:0] OP_R     = 7'h33;
  localparam logic [6:0] OP_I     = 7'h13;
  localparam logic [6:0] OP_BR    = 7'h63;
  localparam logic [6:0] OP_LD    = 7'h03;
  localparam logic [6:0] OP_ST    = 7'h23;
  localparam logic [6:0] OP_JAL   = 7'h6f;
  localparam logic [6:0] OP_JALR  = 7'h67;
  localparam logic [6:0] OP_LUI   = 7'h37;
  localparam logic [6:0] OP_AUIPC = 7'h17;
  localparam logic [6:0] OP_SYS   = 7'h73;
  localparam logic [6:0] OP_FENCE = 7'h0f;

  localparam logic [4:0] A_ADD  = 5'd0;
  localparam logic [4:0] A_SUB  = 5'd1;
  localparam logic [4:0] A_SLL  = 5'd2;
  localparam logic [4:0] A_SLT  = 5'd3;
  localparam logic [4:0] A_SLTU = 5'd4;
  localparam logic [4:0] A_XOR  = 5'd5;
  localparam logic [4:0] A_SRL  = 5'd6;
  localparam logic [4:0] A_SRA  = 5'd7;
  localparam logic [4:0] A_OR   = 5'd8;
  localparam logic [4:0] A_AND  = 5'd9;
  localparam logic [4:0] A_EQ   = 5'd10;
  localparam logic [4:0] A_NE   = 5'd11;
  localparam logic [4:0] A_LT   = 5'd12;
  localparam logic [4:0] A_GE   = 5'd13;
  localparam logic [4:0] A_LTU  = 5'd14;
  localparam logic [4:0] A_GEU  = 5'd15;
  localparam logic [4:0] A_MUL  = 5'd16;

  localparam logic [3:0] T_R     = 4'd0;
  localparam logic [3:0] T_I     = 4'd1;
  localparam logic [3:0] T_BR    = 4'd2;
  localparam logic [3:0] T_LD    = 4'd3;
  localparam logic [3:0] T_ST    = 4'd4;
  localparam logic [3:0] T_JAL   = 4'd5;
  localparam logic [3:0] T_JALR  = 4'd6;
  localparam logic [3:0] T_LUI   = 4'd7;
  localparam logic [3:0] T_AUIPC = 4'd8;
  localparam logic [3:0] T_SYS   = 4'd9;
  localparam logic [3:0] T_FENCE = 4'd10;

  function automatic logic [XLEN-1:0] sx(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  logic [6:0]  opc;
  logic [6:0]  f7;
  logic [2:0]  f3;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_j;
  logic [31:0] imm_u;

  assign opc   = in_inst[6:0];
  assign f3    = in_inst[14:12];
  assign f7    = in_inst[31:25];
  assign imm_i = {{20{in_inst[31]}}, in_inst[31:20]};
  assign imm_s = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign imm_b = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                  in_inst[30:25], in_inst[11:8], 1'b0};
  assign imm_j = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                  in_inst[20], in_inst[30:21], 1'b0};
  assign imm_u = {in_inst[31:12], 12'h000};

  assign rf_rs1_addr = in_inst[19:15];
  assign rf_rs2_addr = in_inst[24:20];

  logic [4:0] base_op;
  logic [4:0] br_op;

  always_comb begin
    unique case (f3)
      3'b000:  base_op = A_ADD;
      3'b001:  base_op = A_SLL;
      3'b010:  base_op = A_SLT;
      3'b011:  base_op = A_SLTU;
      3'b100:  base_op = A_XOR;
      3'b101:  base_op = A_SRL;
      3'b110:  base_op = A_OR;
      default: base_op = A_AND;
    endcase
  end

  always_comb begin
    case (f3)
      3'b001:  br_op = A_NE;
      3'b100:  br_op = A_LT;
      3'b101:  br_op = A_GE;
      3'b110:  br_op = A_LTU;
      3'b111:  br_op = A_GEU;
      default: br_op = A_EQ;
    endcase
  end

  logic [4:0]      aidx;
  logic [3:0]      tidx;
  logic            ill;
  logic [XLEN-1:0] imm;

  always_comb begin
    aidx = A_ADD;
    tidx = T_R;
    ill  = 1'b0;
    imm  = '0;
    case (opc)
      OP_R: begin
        if (f7 == 7'h00) aidx = base_op;
        else if (f7 == 7'h20 && f3 == 3'b000) aidx = A_SUB;
        else if (f7 == 7'h20 && f3 == 3'b101) aidx = A_SRA;
        else if (f7 == 7'h01 && EN_M) aidx = A_MUL + {2'b00, f3};
        else ill = 1'b1;
      end
      OP_I: begin
        tidx = T_I;
        imm  = sx(imm_i);
        aidx = base_op;
        // shifts: upper bits carry only the arithmetic flag and shamt[5]
        if (f3 == 3'b001 || f3 == 3'b101) begin
          if (in_inst[31:26] != 6'b000000 &&
              in_inst[31:26] != 6'b010000) ill = 1'b1;
          if (XLEN == 32 && in_inst[25]) ill = 1'b1;
          if (f3 == 3'b101 && in_inst[30]) aidx = A_SRA;
        end
      end
      OP_BR: begin
        tidx = T_BR;
        imm  = sx(imm_b);
        aidx = br_op;
        if (f3 == 3'b010 || f3 == 3'b011) ill = 1'b1;
      end
      OP_LD: begin
        tidx = T_LD;
        imm  = sx(imm_i);
        if (XLEN == 32 && (f3 == 3'b011 || f3[2:1] == 2'b11))
          ill = 1'b1;
      end
      OP_ST: begin
        tidx = T_ST;
        imm  = sx(imm_s);
        if (f3 > 3'b010) ill = 1'b1;
      end
      OP_JAL: begin
        tidx = T_JAL;
        imm  = sx(imm_j);
      end
      OP_JALR: begin
        tidx = T_JALR;
        imm  = sx(imm_i);
      end
      OP_LUI: begin
        tidx = T_LUI;
        imm  = sx(imm_u);
      end
      OP_AUIPC: begin
        tidx = T_AUIPC;
        imm  = sx(imm_u);
      end
      OP_SYS: begin
        tidx = T_SYS;
        imm  = XLEN'(in_inst[31:20]);
      end
      OP_FENCE: tidx = T_FENCE;
      default:  ill = 1'b1;
    endcase
  end

  pay_t dec;

  always_comb begin
    dec.pc     = in_pc;
    dec.rs1    = in_inst[19:15];
    dec.rs2    = in_inst[24:20];
    dec.rd     = in_inst[11:7];
    dec.funct3 = f3;
    dec.imm    = imm;
    dec.alu    = ill ? '0 : (24'd1 << aidx);
    dec.typ    = ill ? '0 : (11'd1 << tidx);
    dec.ill    = ill;
  end

  pay_t out_q, out_d;
  pay_t skid_q, skid_d;
  logic out_valid_q, out_valid_d;
  logic skid_valid_q, skid_valid_d;
  logic out_free;
  logic acc;

  assign out_free = !out_valid_q || out_ready;
  assign in_ready = SKID ? !skid_valid_q : out_free;
  assign acc      = in_valid && in_ready;

  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_free) begin
      // a full skid blocks in_ready, so it never competes with acc
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = acc;
        if (acc) out_d = dec;
      end
    end else if (SKID && acc) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_pc      = out_q.pc;
  assign out_rs1     = out_q.rs1;
  assign out_rs2     = out_q.rs2;
  assign out_rd      = out_q.rd;
  assign out_funct3  = out_q.funct3;
  assign out_imm     = out_q.imm;
  assign out_alu     = out_q.alu;
  assign out_type    = out_q.typ;
  assign out_illegal = out_q.ill;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Bench for rv_decode_stage: RV32/skid/no-M and RV64/no-skid/M instances
// share stimulus; each is checked against a queue-based decode model.
module tb_rv_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        flush;
  logic        out_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;

  logic        in_ready0, out_valid0, out_ill0;
  logic [4:0]  rf_rs1_0, rf_rs2_0, out_rs1_0, out_rs2_0, out_rd0;
  logic [2:0]  out_f3_0;
  logic [31:0] out_pc0, out_imm0;
  logic [23:0] out_alu0;
  logic [10:0] out_type0;

  logic        in_ready1, out_valid1, out_ill1;
  logic [4:0]  rf_rs1_1, rf_rs2_1, out_rs1_1, out_rs2_1, out_rd1;
  logic [2:0]  out_f3_1;
  logic [31:0] out_pc1;
  logic [63:0] out_imm1;
  logic [23:0] out_alu1;
  logic [10:0] out_type1;

  always #5 clk = ~clk;

  rv_decode_stage #(.XLEN(32), .PC_W(32), .SKID(1'b1), .EN_M(1'b0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
    .in_inst(in_inst), .in_pc(in_pc), .flush(flush),
    .rf_rs1_addr(rf_rs1_0), .rf_rs2_addr(rf_rs2_0),
    .out_valid(out_valid0), .out_ready(out_ready), .out_pc(out_pc0),
    .out_rs1(out_rs1_0), .out_rs2(out_rs2_0), .out_rd(out_rd0),
    .out_funct3(out_f3_0), .out_imm(out_imm0), .out_alu(out_alu0),
    .out_type(out_type0), .out_illegal(out_ill0)
  );

  rv_decode_stage #(.XLEN(64), .PC_W(32), .SKID(1'b0), .EN_M(1'b1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
    .in_inst(in_inst), .in_pc(in_pc), .flush(flush),
    .rf_rs1_addr(rf_rs1_1), .rf_rs2_addr(rf_rs2_1),
    .out_valid(out_valid1), .out_ready(out_ready), .out_pc(out_pc1),
    .out_rs1(out_rs1_1), .out_rs2(out_rs2_1), .out_rd(out_rd1),
    .out_funct3(out_f3_1), .out_imm(out_imm1), .out_alu(out_alu1),
    .out_type(out_type1), .out_illegal(out_ill1)
  );

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } item_t;

  typedef struct packed {
    logic [23:0] alu;
    logic [10:0] typ;
    logic [63:0] imm;
    logic        ill;
  } dec_t;

  item_t q0[$];
  item_t q1[$];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string t, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", t, obs, exp);
    end
  endtask

  // Decode reference: class index, op index and immediate per format.
  function automatic dec_t model(input logic [31:0] i, input bit x64,
                                 input bit em);
    int     rmap[8];
    int     bmap[8];
    int     t;
    int     a;
    bit     ill;
    longint s;
    logic [2:0] f3;
    logic [6:0] f7;
    dec_t d;
    rmap = '{0, 2, 3, 4, 5, 6, 8, 9};
    bmap = '{10, 11, -1, -1, 12, 13, 14, 15};
    f3 = i[14:12];
    f7 = i[31:25];
    t = 0; a = 0; ill = 0; s = 0;
    case (i[6:0])
      7'h33: begin
        t = 0;
        if (f7 == 7'h00) a = rmap[f3];
        else if (f7 == 7'h20 && f3 == 3'd0) a = 1;
        else if (f7 == 7'h20 && f3 == 3'd5) a = 7;
        else if (f7 == 7'h01 && em) a = 16 + int'(f3);
        else ill = 1;
      end
      7'h13: begin
        t = 1;
        s = $signed(i[31:20]);
        a = rmap[f3];
        if (f3 == 3'd1 || f3 == 3'd5) begin
          if (i[31:26] != 6'h00 && i[31:26] != 6'h10) ill = 1;
          if (!x64 && i[25]) ill = 1;
          if (f3 == 3'd5 && i[30]) a = 7;
        end
      end
      7'h63: begin
        t = 2;
        s = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0});
        a = bmap[f3];
        if (a < 0) ill = 1;
      end
      7'h03: begin
        t = 3;
        s = $signed(i[31:20]);
        if (!x64 && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) ill = 1;
      end
      7'h23: begin
        t = 4;
        s = $signed({i[31:25], i[11:7]});
        if (f3 > 3'd2) ill = 1;
      end
      7'h6f: begin
        t = 5;
        s = $signed({i[31], i[19:12], i[20], i[30:21], 1'b0});
      end
      7'h67: begin t = 6; s = $signed(i[31:20]); end
      7'h37: begin t = 7; s = $signed({i[31:12], 12'h000}); end
      7'h17: begin t = 8; s = $signed({i[31:12], 12'h000}); end
      7'h73: begin t = 9; s = longint'({52'd0, i[31:20]}); end
      7'h0f: t = 10;
      default: ill = 1;
    endcase
    d.ill = ill;
    if (ill) begin
      d.alu = '0;
      d.typ = '0;
    end else begin
      d.alu = 24'd1 << a;
      d.typ = 11'd1 << t;
    end
    d.imm = x64 ? 64'(s) : (64'(s) & 64'hFFFF_FFFF);
    return d;
  endfunction

  task automatic chk_pay(input string t, input item_t it, input bit x64,
                         input logic [31:0] pc, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [2:0] f3, input logic [63:0] imm,
                         input logic [23:0] alu, input logic [10:0] typ,
                         input logic ill);
    dec_t e;
    e = model(it.inst, x64, x64);
    chk({t, ".pc"}, 64'(pc), 64'(it.pc));
    chk({t, ".regs"}, 64'({rs1, rs2, rd, f3}),
        64'({it.inst[19:15], it.inst[24:20], it.inst[11:7], it.inst[14:12]}));
    chk({t, ".imm"}, imm, e.imm);
    chk({t, ".alu"}, 64'(alu), 64'(e.alu));
    chk({t, ".type"}, 64'(typ), 64'(e.typ));
    chk({t, ".illegal"}, 64'(ill), 64'(e.ill));
  endtask

  // One cycle: drive at negedge, check, advance models at posedge.
  task automatic step(input bit v, input logic [31:0] inst,
                      input logic [31:0] pc, input bit ordy, input bit fl);
    bit acc0, acc1, drn0, drn1;
    item_t it;
    in_valid = v; in_inst = inst; in_pc = pc;
    out_ready = ordy; flush = fl;
    #1;
    chk("rf_rs1_0", 64'(rf_rs1_0), 64'(inst[19:15]));
    chk("rf_rs2_1", 64'(rf_rs2_1), 64'(inst[24:20]));
    chk("in_ready0", 64'(in_ready0), 64'(q0.size() < 2));
    chk("in_ready1", 64'(in_ready1), 64'(q1.size() == 0 || ordy));
    chk("out_valid0", 64'(out_valid0), 64'(q0.size() != 0));
    chk("out_valid1", 64'(out_valid1), 64'(q1.size() != 0));
    if (q0.size() != 0)
      chk_pay("dut0", q0[0], 1'b0, out_pc0, out_rs1_0, out_rs2_0, out_rd0,
              out_f3_0, {32'd0, out_imm0}, out_alu0, out_type0, out_ill0);
    if (q1.size() != 0)
      chk_pay("dut1", q1[0], 1'b1, out_pc1, out_rs1_1, out_rs2_1, out_rd1,
              out_f3_1, out_imm1, out_alu1, out_type1, out_ill1);
    acc0 = v && q0.size() < 2;
    acc1 = v && (q1.size() == 0 || ordy);
    drn0 = ordy && q0.size() != 0;
    drn1 = ordy && q1.size() != 0;
    it.inst = inst;
    it.pc = pc;
    @(posedge clk);
    if (fl) begin
      q0.delete();
      q1.delete();
    end else begin
      if (drn0) void'(q0.pop_front());
      if (drn1) void'(q1.pop_front());
      if (acc0) q0.push_back(it);
      if (acc1) q1.push_back(it);
    end
    @(negedge clk);
  endtask

  task automatic chk_reset(input string t);
    chk({t, ".out_valid0"}, 64'(out_valid0), 64'd0);
    chk({t, ".in_ready0"}, 64'(in_ready0), 64'd1);
    chk({t, ".out_valid1"}, 64'(out_valid1), 64'd0);
    chk({t, ".in_ready1"}, 64'(in_ready1), 64'd1);
    chk({t, ".pay0"}, 64'(|{out_pc0, out_rs1_0, out_rs2_0, out_rd0, out_f3_0,
        out_imm0, out_alu0, out_type0, out_ill0}), 64'd0);
    chk({t, ".pay1"}, 64'(|{out_pc1, out_rs1_1, out_rs2_1, out_rd1, out_f3_1,
        out_imm1, out_alu1, out_type1, out_ill1}), 64'd0);
  endtask

  function automatic logic [31:0] rnd_inst();
    logic [31:0] r;
    int k;
    r = $urandom;
    k = $urandom_range(0, 11);
    case (k)
      0: r[6:0] = 7'h33;
      1: r[6:0] = 7'h13;
      2: r[6:0] = 7'h63;
      3: r[6:0] = 7'h03;
      4: r[6:0] = 7'h23;
      5: r[6:0] = 7'h6f;
      6: r[6:0] = 7'h67;
      7: r[6:0] = 7'h37;
      8: r[6:0] = 7'h17;
      9: r[6:0] = 7'h73;
      10: r[6:0] = 7'h0f;
      default: ;
    endcase
    k = $urandom_range(0, 3);
    if (k == 0) r[31:25] = 7'h00;
    else if (k == 1) r[31:25] = 7'h20;
    else if (k == 2) r[31:25] = 7'h01;
    return r;
  endfunction

  initial begin
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_inst = '0; in_pc = '0;
    repeat (2) @(negedge clk);
    chk_reset("reset");
    reset = 1'b0;

    step(1'b1, 32'hFFB10093, 32'h100, 1'b1, 1'b0);
    chk("addi.alu", 64'(out_alu0), 64'h1);
    chk("addi.type", 64'(out_type0), 64'h2);
    chk("addi.imm", 64'(out_imm0), 64'hFFFF_FFFB);
    chk("addi.imm64", out_imm1, 64'hFFFF_FFFF_FFFF_FFFB);
    chk("addi.rs1rd", 64'({out_rs1_0, out_rd0}), 64'({5'd2, 5'd1}));
    step(1'b1, 32'h405201B3, 32'h104, 1'b1, 1'b0);
    chk("sub.alu", 64'(out_alu0), 64'h2);
    chk("sub.type", 64'(out_type0), 64'h1);
    chk("sub.regs", 64'({out_rs1_0, out_rs2_0, out_rd0}),
        64'({5'd4, 5'd5, 5'd3}));
    step(1'b1, 32'h00208463, 32'h108, 1'b1, 1'b0);
    chk("beq.type", 64'(out_type0), 64'h4);
    chk("beq.alu", 64'(out_alu0), 64'h400);
    chk("beq.imm", 64'(out_imm0), 64'h8);
    chk("beq.imm64", out_imm1, 64'h8);
    step(1'b1, 32'h023100B3, 32'h10C, 1'b1, 1'b0);
    chk("mul.ill0", 64'({out_ill0, out_alu0, out_type0}), 64'({1'b1, 35'd0}));
    chk("mul.alu1", 64'({out_ill1, out_alu1}), 64'({1'b0, 24'h10000}));
    step(1'b1, 32'h00000000, 32'h110, 1'b1, 1'b0);
    chk("zero.ill", 64'({out_ill0, out_ill1}), 64'b11);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    step(1'b1, 32'h00100093, 32'h200, 1'b0, 1'b0);
    step(1'b1, 32'h00200113, 32'h204, 1'b0, 1'b0);
    chk("bp.holdA", 64'(out_pc0), 64'h200);
    chk("bp.rdy_low", 64'(in_ready0), 64'd0);
    step(1'b1, 32'h00300193, 32'h208, 1'b0, 1'b0);
    chk("bp.stillA", 64'(out_pc0), 64'h200);
    step(1'b1, 32'h00300193, 32'h208, 1'b1, 1'b0);
    chk("bp.outB", 64'({out_valid0, out_pc0}), 64'({1'b1, 32'h204}));
    chk("bp.rdy_back", 64'(in_ready0), 64'd1);
    step(1'b1, 32'h00300193, 32'h208, 1'b1, 1'b0);
    chk("bp.outC", 64'({out_valid0, out_pc0}), 64'({1'b1, 32'h208}));
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("bp.empty", 64'(out_valid0), 64'd0);

    step(1'b1, 32'h00100093, 32'h300, 1'b0, 1'b0);
    step(1'b1, 32'h00200113, 32'h304, 1'b0, 1'b0);
    step(1'b1, 32'h00300193, 32'h308, 1'b0, 1'b1);
    chk("flush.valid", 64'({out_valid0, out_valid1}), 64'd0);
    chk("flush.ready", 64'(in_ready0), 64'd1);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("flush.nob", 64'(out_valid0), 64'd0);

    step(1'b1, 32'h00500293, 32'h400, 1'b0, 1'b0);
    step(1'b1, 32'h00600313, 32'h404, 1'b0, 1'b0);
    in_valid = 1'b1;
    reset = 1'b1;
    #1;
    chk_reset("midreset");
    @(posedge clk);
    @(negedge clk);
    chk_reset("rst_hold");
    reset = 1'b0;
    q0.delete();
    q1.delete();

    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 3) != 0, rnd_inst(), $urandom,
           $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
    end
    repeat (3) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
